// File: rtl/alien_row_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : invaders_pkg
//  Brief    : Shared sprite geometry, band width and FSM encoding.
//  Revision : 1.0
// ============================================================================
package invaders_pkg;

    localparam int SPRITE_ROWS = 12;
    localparam int SPRITE_W    = 12;
    localparam int BAND_W      = 3;
    localparam int ROW_IDX_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DONE  = 3'd3,
        ST_EXT   = 3'd4
    } state_t;

    function automatic logic row_in_range(input logic [ROW_IDX_W-1:0] idx);
        return idx < ROW_IDX_W'(SPRITE_ROWS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alien_row_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : alien_row_fetch_if
//  Brief    : Line request, sprite ROM and secondary requester signals.
//  Revision : 1.0
// ============================================================================
interface alien_row_fetch_if #(
    parameter int Y_WIDTH = 10
) ();
    import invaders_pkg::*;

    logic                 line_start;
    logic [Y_WIDTH-1:0]   vpos;
    logic [Y_WIDTH-1:0]   form_y;
    logic [ROW_IDX_W-1:0] rom_row_index;
    logic [SPRITE_W-1:0]  rom_row_data;
    logic [SPRITE_W-1:0]  line_bits;
    logic [BAND_W-1:0]    line_band;
    logic                 line_hit;
    logic                 line_ready;
    logic                 ext_req;
    logic [ROW_IDX_W-1:0] ext_index;
    logic                 ext_gnt;
    logic [SPRITE_W-1:0]  ext_data;

    modport master (
        input  line_start, vpos, form_y, rom_row_data, ext_req, ext_index,
        output rom_row_index, line_bits, line_band, line_hit, line_ready,
               ext_gnt, ext_data
    );

    modport slave (
        output line_start, vpos, form_y, rom_row_data, ext_req, ext_index,
        input  rom_row_index, line_bits, line_band, line_hit, line_ready,
               ext_gnt, ext_data
    );
endinterface
`default_nettype wire

// File: rtl/alien_row_fetch_band_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alien_band_decode
//  Brief    : Maps a line offset from the formation top to band, sprite row, hit.
//  Revision : 1.0
// ============================================================================
module alien_band_decode
    import invaders_pkg::*;
#(
    parameter int Y_WIDTH        = 10,
    parameter int NUM_ROWS       = 5,
    parameter int ROW_PITCH_LOG2 = 5,
    parameter int SCALE_SHIFT    = 1
) (
    input  wire logic [Y_WIDTH-1:0]   vpos_i,
    input  wire logic [Y_WIDTH-1:0]   form_y_i,
    output logic      [BAND_W-1:0]    band_o,
    output logic      [ROW_IDX_W-1:0] srow_o,
    output logic                      hit_o
);
    localparam logic [Y_WIDTH:0] LIMIT = (Y_WIDTH+1)'(NUM_ROWS << ROW_PITCH_LOG2);

    logic [Y_WIDTH:0]          w_dy;
    logic [ROW_PITCH_LOG2-1:0] w_sr;

    // One extra bit so the subtraction's sign bit marks lines above the formation.
    assign w_dy   = {1'b0, vpos_i} - {1'b0, form_y_i};
    assign w_sr   = w_dy[ROW_PITCH_LOG2-1:0] >> SCALE_SHIFT;
    assign band_o = BAND_W'(w_dy >> ROW_PITCH_LOG2);
    assign srow_o = ROW_IDX_W'(w_sr);
    assign hit_o  = !w_dy[Y_WIDTH] && (w_dy < LIMIT) && (int'(w_sr) < SPRITE_ROWS);

endmodule
`default_nettype wire

// File: rtl/alien_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : alien_row_fetch
//  Brief    : Per-scanline alien sprite row fetch with a secondary ROM requester.
//  Revision : 1.0
// ============================================================================
module alien_row_fetch
    import invaders_pkg::*;
#(
    parameter int Y_WIDTH        = 10,
    parameter int NUM_ROWS       = 5,
    parameter int ROW_PITCH_LOG2 = 5,
    parameter int SCALE_SHIFT    = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alien_row_fetch_if.master  bus
);
    state_t               state_q;
    logic [Y_WIDTH-1:0]   vpos_q, form_y_q, pend_vpos_q, pend_form_y_q;
    logic                 pend_q, hit_q, ext_oob_q, ext_phase_q;
    logic [BAND_W-1:0]    band_q, line_band_q;
    logic [ROW_IDX_W-1:0] rom_row_index_q;
    logic [SPRITE_W-1:0]  hold_q, line_bits_q, ext_data_q;
    logic                 line_hit_q, line_ready_q, ext_gnt_q;

    logic [BAND_W-1:0]    w_band;
    logic [ROW_IDX_W-1:0] w_srow;
    logic                 w_hit;

    alien_band_decode #(
        .Y_WIDTH        (Y_WIDTH),
        .NUM_ROWS       (NUM_ROWS),
        .ROW_PITCH_LOG2 (ROW_PITCH_LOG2),
        .SCALE_SHIFT    (SCALE_SHIFT)
    ) u_decode (
        .vpos_i   (vpos_q),
        .form_y_i (form_y_q),
        .band_o   (w_band),
        .srow_o   (w_srow),
        .hit_o    (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            vpos_q          <= '0;
            form_y_q        <= '0;
            pend_q          <= 1'b0;
            pend_vpos_q     <= '0;
            pend_form_y_q   <= '0;
            hit_q           <= 1'b0;
            band_q          <= '0;
            hold_q          <= '0;
            ext_oob_q       <= 1'b0;
            ext_phase_q     <= 1'b0;
            rom_row_index_q <= '0;
            line_bits_q     <= '0;
            line_band_q     <= '0;
            line_hit_q      <= 1'b0;
            line_ready_q    <= 1'b0;
            ext_gnt_q       <= 1'b0;
            ext_data_q      <= '0;
        end else begin
            line_ready_q <= 1'b0;
            ext_gnt_q    <= 1'b0;

            // A line start that cannot be taken now waits in a single slot; newest wins.
            if (state_q != ST_IDLE && bus.line_start) begin
                pend_q        <= 1'b1;
                pend_vpos_q   <= bus.vpos;
                pend_form_y_q <= bus.form_y;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.line_start) begin
                        vpos_q   <= bus.vpos;
                        form_y_q <= bus.form_y;
                        pend_q   <= 1'b0;
                        state_q  <= ST_CALC;
                    end else if (pend_q) begin
                        vpos_q   <= pend_vpos_q;
                        form_y_q <= pend_form_y_q;
                        pend_q   <= 1'b0;
                        state_q  <= ST_CALC;
                    end else if (bus.ext_req && !ext_gnt_q) begin
                        rom_row_index_q <= row_in_range(bus.ext_index) ? bus.ext_index : '0;
                        ext_oob_q       <= !row_in_range(bus.ext_index);
                        ext_phase_q     <= 1'b0;
                        state_q         <= ST_EXT;
                    end
                end
                ST_CALC: begin
                    band_q          <= w_band;
                    hit_q           <= w_hit;
                    rom_row_index_q <= w_hit ? w_srow : '0;
                    state_q         <= ST_FETCH;
                end
                ST_FETCH: begin
                    hold_q  <= bus.rom_row_data;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    line_bits_q     <= hit_q ? hold_q : '0;
                    line_band_q     <= hit_q ? band_q : '0;
                    line_hit_q      <= hit_q;
                    line_ready_q    <= 1'b1;
                    rom_row_index_q <= '0;
                    state_q         <= ST_IDLE;
                end
                ST_EXT: begin
                    // First cycle samples the ROM, second publishes data with the grant.
                    if (!ext_phase_q) begin
                        hold_q      <= ext_oob_q ? '0 : bus.rom_row_data;
                        ext_phase_q <= 1'b1;
                    end else begin
                        ext_data_q      <= hold_q;
                        ext_gnt_q       <= 1'b1;
                        ext_phase_q     <= 1'b0;
                        rom_row_index_q <= '0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_row_index = rom_row_index_q;
    assign bus.line_bits     = line_bits_q;
    assign bus.line_band     = line_band_q;
    assign bus.line_hit      = line_hit_q;
    assign bus.line_ready    = line_ready_q;
    assign bus.ext_gnt       = ext_gnt_q;
    assign bus.ext_data      = ext_data_q;

endmodule
`default_nettype wire

// File: doc/alien_row_fetch.md
# alien_row_fetch

Scanline-driven controller for the single combinational alien sprite ROM (4-bit row index in, 12-bit row bitmap out). At each `line_start` it decides which alien band of the formation, if any, the upcoming line crosses. It fetches the matching sprite row and presents it, registered, to the pixel renderer. When the ROM is otherwise idle it serves a secondary requester (collision checker or HUD) through a req/gnt handshake.

## Interface
Parameters:
- `Y_WIDTH`, 10: width of vertical coordinates.
- `NUM_ROWS`, 5: number of alien bands in the formation, max 8.
- `ROW_PITCH_LOG2`, 5: band pitch is `1 << ROW_PITCH_LOG2` lines (32).
- `SCALE_SHIFT`, 1: each ROM row is shown on `1 << SCALE_SHIFT` consecutive lines.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `line_start`  in  1  one-cycle pulse at start of horizontal blank.
- `vpos`  in  Y_WIDTH  line about to be drawn; sampled on `line_start`.
- `form_y`  in  Y_WIDTH  top line of the formation; sampled on `line_start`.
- `rom_row_index`  out  4  registered index to the sprite ROM.
- `rom_row_data`  in  12  ROM output (combinational from `rom_row_index`).
- `line_bits`  out  12  sprite row bitmap for the line; 0 on a miss.
- `line_band`  out  3  band number hit; 0 on a miss.
- `line_hit`  out  1  line intersects a sprite row.
- `line_ready`  out  1  one-cycle pulse when the `line_*` outputs update.
- `ext_req`  in  1  secondary request; held until `ext_gnt`.
- `ext_index`  in  4  row requested; stable while `ext_req` is high.
- `ext_gnt`  out  1  one-cycle grant pulse; `ext_data` is valid in that cycle.
- `ext_data`  out  12  fetched row; held until the next grant.

## Operation
- FSM states: IDLE, CALC, FETCH, DONE, EXT.
- IDLE with `line_start`, or with the pending flag set: capture `vpos` and `form_y` (or take the pending capture), then go to CALC. This path has priority over `ext_req`.
- CALC: compute `dy = vpos - form_y` at Y_WIDTH+1 bits, signed.
  - Hit requires `dy >= 0`, `dy < NUM_ROWS << ROW_PITCH_LOG2`, and `srow < 12`.
  - `band = dy >> ROW_PITCH_LOG2`.
  - `srow = dy[ROW_PITCH_LOG2-1:0] >> SCALE_SHIFT`.
  - Register `band`, `srow` and the hit flag. Load `rom_row_index <= hit ? srow : 0`.
- FETCH: sample `rom_row_data` into a holding register. Go to DONE.
- DONE: update `line_bits` (data masked to 0 on a miss), `line_band` and `line_hit`. Pulse `line_ready`. Set `rom_row_index` to 0. Go to IDLE.
- IDLE with `ext_req`, no `line_start`, nothing pending and `ext_gnt` low: go to EXT.
  - `rom_row_index <= (ext_index < 12) ? ext_index : 0`.
- EXT: latch `ext_data` (0 if `ext_index >= 12`). Pulse `ext_gnt` on the next cycle. Return to IDLE.
- IDLE ignores `ext_req` in the cycle `ext_gnt` is high; this prevents a duplicate grant.
- `line_start` outside IDLE: capture `vpos` and `form_y` into a single pending slot and set the pending flag.
  - A second pulse before service overwrites the slot.
  - The flag clears when the FSM leaves IDLE for CALC.
- The miss path always passes through FETCH, giving constant latency.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0 (`rom_row_index`, `line_bits`, `line_band`, `line_hit`, `line_ready`, `ext_gnt`, `ext_data`). Pending flag cleared.
- Reset mid-operation aborts any fetch with no `line_ready` or `ext_gnt`. The requester must re-present.
- Line latency: `line_start` sampled at edge T gives outputs updated at edge T+3 and `line_ready` high in the cycle after T+3. This holds for hits and misses.
- Ext latency: `ext_req` sampled in IDLE at edge E gives `ext_gnt` high in the cycle after E+2.
- A `line_start` arriving during EXT is serviced from IDLE. Line latency then stretches by at most 2 cycles.
- `rom_row_index` is stable for the whole FETCH/EXT cycle. The ROM's combinational path needs only one cycle.

## Structure
- Shared package `invaders_pkg`: `SPRITE_ROWS = 12`, `SPRITE_W = 12`, the FSM state encoding, and the band-width constant (3).
- One combinational sub-module `alien_band_decode` covers `dy` to `band`, `srow` and hit. The renderer and collision logic reuse it.

## Test plan
All scenarios use default parameters and `form_y = 40`. ROM rows: 0 = 0x0E0, 3 = 0x6EC, 4 = 0xFFE, 11 = 0x000.
- `vpos = 40`, `line_start` -> after 3 edges `line_ready`; `line_bits = 0x0E0`, `line_band = 0`, `line_hit = 1`.
- `vpos = 48` -> 0xFFE, band 0. `vpos = 111` -> `srow = 3`, band 2, 0x6EC. `vpos = 126` -> `srow = 11`, band 2, `line_hit = 1`, bits 0x000.
- Misses, each with `line_bits = 0`, `line_hit = 0` and `line_ready` still at 3 edges:
  - `vpos = 64` (`srow = 12`, gap).
  - `vpos = 39` (negative `dy`).
  - `vpos = 200` (past the last band).
- `ext_req` with `ext_index = 4` while IDLE -> `ext_gnt` one cycle with `ext_data = 0xFFE`. Held `ext_req` is not re-granted in the grant cycle. `ext_index = 13` -> grant with `ext_data = 0`.
- `line_start` (`vpos = 48`) one cycle after `ext_req` is accepted -> `ext_gnt` first, then `line_ready` 5 edges after `line_start` with 0xFFE. Simultaneous `line_start` and `ext_req` in IDLE -> line serviced first.
- `rst_n` low during FETCH -> no `line_ready`, all outputs 0. After release, a fresh `line_start` yields normal results.
